// File: rtl/commit_tracer.sv
// Writeback commit tracer: registers each retired instruction, keeps a shadow GPR file,
// counts commits and tracks halt (self-loop plus delay slot) and watchdog hang.
module commit_tracer #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_instr,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        io_commit_valid,
    output logic [31:0] io_commit_pc,
    output logic [31:0] io_commit_instr,
    output logic [31:0] io_commit_gpr_0,
    output logic [31:0] io_commit_gpr_1,
    output logic [31:0] io_commit_gpr_2,
    output logic [31:0] io_commit_gpr_3,
    output logic [31:0] io_commit_gpr_4,
    output logic [31:0] io_commit_gpr_5,
    output logic [31:0] io_commit_gpr_6,
    output logic [31:0] io_commit_gpr_7,
    output logic [31:0] io_commit_gpr_8,
    output logic [31:0] io_commit_gpr_9,
    output logic [31:0] io_commit_gpr_10,
    output logic [31:0] io_commit_gpr_11,
    output logic [31:0] io_commit_gpr_12,
    output logic [31:0] io_commit_gpr_13,
    output logic [31:0] io_commit_gpr_14,
    output logic [31:0] io_commit_gpr_15,
    output logic [31:0] io_commit_gpr_16,
    output logic [31:0] io_commit_gpr_17,
    output logic [31:0] io_commit_gpr_18,
    output logic [31:0] io_commit_gpr_19,
    output logic [31:0] io_commit_gpr_20,
    output logic [31:0] io_commit_gpr_21,
    output logic [31:0] io_commit_gpr_22,
    output logic [31:0] io_commit_gpr_23,
    output logic [31:0] io_commit_gpr_24,
    output logic [31:0] io_commit_gpr_25,
    output logic [31:0] io_commit_gpr_26,
    output logic [31:0] io_commit_gpr_27,
    output logic [31:0] io_commit_gpr_28,
    output logic [31:0] io_commit_gpr_29,
    output logic [31:0] io_commit_gpr_30,
    output logic [31:0] io_commit_gpr_31,
    output logic [31:0] commit_count,
    output logic        halted,
    output logic        hung
);

    localparam logic [31:0] HALT_INSTR = 32'h1000FFFF;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, HALT_DS, HALTED, HUNG} state_t;

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd;
    logic [31:1][31:0] regs;
    logic              active, accept, wd_expire;

    assign active    = (state == RUN) || (state == HALT_DS);
    assign accept    = wb_valid && active;
    // A commit landing on the last watchdog cycle wins over the timeout.
    assign wd_expire = active && !accept && (wd == WD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (accept && wb_instr == HALT_INSTR) state_nxt = HALT_DS;
                else if (wd_expire)                   state_nxt = HUNG;
            end
            HALT_DS: begin
                if (accept)         state_nxt = HALTED;
                else if (wd_expire) state_nxt = HUNG;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = HUNG;
        endcase
    end

    always_comb begin
        halted = (state == HALTED);
        hung   = (state == HUNG);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     wd <= '0;
        else if (accept) wd <= '0;
        else if (active && !wd_expire) wd <= wd + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io_commit_valid <= 1'b0;
            io_commit_pc    <= '0;
            io_commit_instr <= '0;
            commit_count    <= '0;
            regs            <= '0;
        end else begin
            io_commit_valid <= accept;
            if (accept) begin
                io_commit_pc    <= wb_pc;
                io_commit_instr <= wb_instr;
                commit_count    <= commit_count + 32'd1;
                if (wb_wen && wb_waddr != 5'd0) regs[wb_waddr] <= wb_wdata;
            end
        end
    end

    assign io_commit_gpr_0  = '0;
    assign io_commit_gpr_1  = regs[1];
    assign io_commit_gpr_2  = regs[2];
    assign io_commit_gpr_3  = regs[3];
    assign io_commit_gpr_4  = regs[4];
    assign io_commit_gpr_5  = regs[5];
    assign io_commit_gpr_6  = regs[6];
    assign io_commit_gpr_7  = regs[7];
    assign io_commit_gpr_8  = regs[8];
    assign io_commit_gpr_9  = regs[9];
    assign io_commit_gpr_10 = regs[10];
    assign io_commit_gpr_11 = regs[11];
    assign io_commit_gpr_12 = regs[12];
    assign io_commit_gpr_13 = regs[13];
    assign io_commit_gpr_14 = regs[14];
    assign io_commit_gpr_15 = regs[15];
    assign io_commit_gpr_16 = regs[16];
    assign io_commit_gpr_17 = regs[17];
    assign io_commit_gpr_18 = regs[18];
    assign io_commit_gpr_19 = regs[19];
    assign io_commit_gpr_20 = regs[20];
    assign io_commit_gpr_21 = regs[21];
    assign io_commit_gpr_22 = regs[22];
    assign io_commit_gpr_23 = regs[23];
    assign io_commit_gpr_24 = regs[24];
    assign io_commit_gpr_25 = regs[25];
    assign io_commit_gpr_26 = regs[26];
    assign io_commit_gpr_27 = regs[27];
    assign io_commit_gpr_28 = regs[28];
    assign io_commit_gpr_29 = regs[29];
    assign io_commit_gpr_30 = regs[30];
    assign io_commit_gpr_31 = regs[31];

endmodule

// File: tb/tb_commit_tracer.sv
// Directed bench for commit_tracer: expected commits go into a scoreboard queue when
// driven and are checked against each io_commit_valid pulse.
module tb_commit_tracer;

    localparam int unsigned TO = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
        int          gidx;
        logic [31:0] gval;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid, wb_wen;
    logic [31:0] wb_pc, wb_instr, wb_wdata;
    logic [4:0]  wb_waddr;
    logic        io_commit_valid, halted, hung;
    logic [31:0] io_commit_pc, io_commit_instr, commit_count;
    logic [31:0] g [32];

    exp_t        sb [$];
    logic [31:0] model_gpr [32];
    logic [31:0] model_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    commit_tracer #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .io_commit_valid(io_commit_valid), .io_commit_pc(io_commit_pc),
        .io_commit_instr(io_commit_instr),
        .io_commit_gpr_0(g[0]),   .io_commit_gpr_1(g[1]),   .io_commit_gpr_2(g[2]),
        .io_commit_gpr_3(g[3]),   .io_commit_gpr_4(g[4]),   .io_commit_gpr_5(g[5]),
        .io_commit_gpr_6(g[6]),   .io_commit_gpr_7(g[7]),   .io_commit_gpr_8(g[8]),
        .io_commit_gpr_9(g[9]),   .io_commit_gpr_10(g[10]), .io_commit_gpr_11(g[11]),
        .io_commit_gpr_12(g[12]), .io_commit_gpr_13(g[13]), .io_commit_gpr_14(g[14]),
        .io_commit_gpr_15(g[15]), .io_commit_gpr_16(g[16]), .io_commit_gpr_17(g[17]),
        .io_commit_gpr_18(g[18]), .io_commit_gpr_19(g[19]), .io_commit_gpr_20(g[20]),
        .io_commit_gpr_21(g[21]), .io_commit_gpr_22(g[22]), .io_commit_gpr_23(g[23]),
        .io_commit_gpr_24(g[24]), .io_commit_gpr_25(g[25]), .io_commit_gpr_26(g[26]),
        .io_commit_gpr_27(g[27]), .io_commit_gpr_28(g[28]), .io_commit_gpr_29(g[29]),
        .io_commit_gpr_30(g[30]), .io_commit_gpr_31(g[31]),
        .commit_count(commit_count), .halted(halted), .hung(hung)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        model_cnt = '0;
        for (int i = 0; i < 32; i++) model_gpr[i] = '0;
    endtask

    // Drive one cycle of writeback; push an expectation only when the bench predicts acceptance.
    task automatic drive(input logic v, input logic push, input logic [31:0] pc,
                         input logic [31:0] instr, input logic wen, input logic [4:0] addr,
                         input logic [31:0] data, input int gidx);
        exp_t e;
        wb_valid = v; wb_pc = pc; wb_instr = instr;
        wb_wen = wen; wb_waddr = addr; wb_wdata = data;
        if (push) begin
            model_cnt = model_cnt + 1;
            if (wen && addr != 5'd0) model_gpr[addr] = data;
            e.pc = pc; e.instr = instr; e.count = model_cnt;
            e.gidx = gidx; e.gval = model_gpr[gidx];
            sb.push_back(e);
        end
    endtask

    // One clock edge, then compare any pulse against the scoreboard head.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'd0, io_commit_valid}, {31'd0, sb.size() != 0});
        if (io_commit_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".pc"}, io_commit_pc, e.pc);
            chk({tag, ".instr"}, io_commit_instr, e.instr);
            chk({tag, ".count"}, commit_count, e.count);
            chk($sformatf("%s.gpr%0d", tag, e.gidx), g[e.gidx], e.gval);
        end
        wb_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 0);
            step(tag);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, io_commit_valid}, 32'd0);
        chk({tag, ".pc"}, io_commit_pc, 32'd0);
        chk({tag, ".instr"}, io_commit_instr, 32'd0);
        chk({tag, ".count"}, commit_count, 32'd0);
        chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".hung"}, {31'd0, hung}, 32'd0);
        chk({tag, ".gpr5"}, g[5], 32'd0);
        chk({tag, ".gpr8"}, g[8], 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        check_zero("rst");
        // wb_valid held during reset must be ignored
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 5'd3, 32'h55, 0);
        step("rst_valid");
        drive(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 5'd3, 32'h66, 0);
        step("rst_valid");
        chk("rst_valid.gpr3", g[3], 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        wb_valid = 1'b0; wb_wen = 1'b0; wb_pc = '0; wb_instr = '0;
        wb_waddr = '0; wb_wdata = '0;
        do_reset();

        drive(1'b1, 1'b1, 32'hBFC00000, 32'h24080005, 1'b1, 5'd8, 32'd5, 8);
        step("first");
        idle("first_after", 1);
        chk("first_hold.pc", io_commit_pc, 32'hBFC00000);

        drive(1'b1, 1'b1, 32'hBFC00004, 32'h00000000, 1'b1, 5'd0, 32'hDEADBEEF, 0);
        step("r0");

        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 32'hBFC00004 + 32'(4 * i), 32'h24020000 + 32'(i), 1'b1,
                  5'd2, 32'(i), 2);
            step("b2b");
        end
        chk("b2b.gpr8_kept", g[8], 32'd5);

        // commit on the last watchdog cycle is accepted
        idle("wd_near", TO - 1);
        drive(1'b1, 1'b1, 32'hBFC00100, 32'h0, 1'b1, 5'd4, 32'h44, 4);
        step("wd_edge");
        chk("wd_edge.hung", {31'd0, hung}, 32'd0);
        idle("wd_run", TO - 1);
        chk("wd_pre.hung", {31'd0, hung}, 32'd0);
        idle("wd_fire", 1);
        chk("wd_fire.hung", {31'd0, hung}, 32'd1);
        drive(1'b1, 1'b0, 32'hBFC00200, 32'h0, 1'b1, 5'd4, 32'h99, 0);
        step("hung_ign");
        chk("hung_ign.count", commit_count, model_cnt);
        chk("hung_ign.gpr4", g[4], 32'h44);
        chk("hung_ign.hung", {31'd0, hung}, 32'd1);

        do_reset();
        drive(1'b1, 1'b1, 32'hBFC00300, 32'h1000FFFF, 1'b0, 5'd0, 32'd0, 0);
        step("halt_b");
        drive(1'b1, 1'b1, 32'hBFC00304, 32'h24090007, 1'b1, 5'd9, 32'd7, 9);
        step("halt_ds");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'hBFC00308, 32'h24090001, 1'b1, 5'd9, 32'd1, 0);
            step("halted_ign");
        end
        chk("halted.flag", {31'd0, halted}, 32'd1);
        chk("halted.count", commit_count, 32'd2);
        chk("halted.gpr9", g[9], 32'd7);

        // reset mid-pulse clears everything without a clock edge
        do_reset();
        drive(1'b1, 1'b1, 32'hBFC00400, 32'h24051234, 1'b1, 5'd5, 32'h1234, 5);
        step("pre_rst");
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_zero("mid_rst");
        #1;
        resetn = 1'b1;
        drive(1'b1, 1'b1, 32'hBFC00500, 32'h0, 1'b1, 5'd6, 32'h66, 5);
        step("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_tracer.md
COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 Parameter TIMEOUT, default 4096: consecutive commit-free cycles before the hung flag is raised; legal range 2..2^20.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 wb_valid  in  1  one instruction retires from writeback this cycle.
REQ-005 wb_pc  in  32  PC of the retiring instruction.
REQ-006 wb_instr  in  32  encoding of the retiring instruction.
REQ-007 wb_wen  in  1  retiring instruction writes a GPR.
REQ-008 wb_waddr  in  5  destination GPR index.
REQ-009 wb_wdata  in  32  destination GPR value.
REQ-010 io_commit_valid  out  1  one-cycle pulse per accepted commit.
REQ-011 io_commit_pc  out  32  PC of the last commit.
REQ-012 io_commit_instr  out  32  encoding of the last commit.
REQ-013 io_commit_gpr_0 .. io_commit_gpr_31  out  32 each  architectural GPR snapshot after the last commit.
REQ-014 commit_count  out  32  number of accepted commits since reset.
REQ-015 halted  out  1  program reached the self-loop halt and its delay slot.
REQ-016 hung  out  1  watchdog expired; sticky.

Function
REQ-017 Latency SHALL be one cycle: wb_valid sampled high at edge k gives io_commit_valid high from edge k until edge k+1.
REQ-018 io_commit_valid SHALL be high for exactly one cycle per accepted commit; back-to-back wb_valid gives back-to-back pulses.
REQ-019 io_commit_pc/instr SHALL load with every accepted commit and hold otherwise.
REQ-020 Shadow file: 32x32 regs; an accepted commit with wb_wen=1 and wb_waddr!=0 writes wb_wdata at the same edge, so the io_commit_gpr_* outputs in the pulse cycle include that write.
REQ-021 wb_waddr=0 writes SHALL be discarded; io_commit_gpr_0 is always 0.
REQ-022 commit_count SHALL increment by 1 per accepted commit and wrap 0xFFFFFFFF -> 0.
REQ-023 FSM states: RUN, HALT_DS, HALTED, HUNG.
REQ-024 RUN: an accepted commit with wb_instr=0x1000FFFF (b .) moves to HALT_DS.
REQ-025 HALT_DS: the next wb_valid is accepted (delay slot) and moves to HALTED.
REQ-026 HALTED: wb_valid ignored; no pulse, no GPR write, count frozen; halted=1.
REQ-027 Watchdog counter: active in RUN and HALT_DS, cleared on every accepted commit, otherwise incremented; on reaching TIMEOUT moves to HUNG.
REQ-028 HUNG: hung=1, wb_valid ignored, all outputs frozen, exit only by reset.
REQ-029 If wb_valid arrives in the cycle the watchdog would reach TIMEOUT, the commit SHALL be accepted and the watchdog cleared; no transition to HUNG.
REQ-030 A 0x1000FFFF commit in HALT_DS SHALL be accepted as the delay slot and go to HALTED.

Reset
REQ-031 Asserting resetn low SHALL clear, immediately and independent of clk: io_commit_valid, io_commit_pc, io_commit_instr, all io_commit_gpr_*, commit_count, halted, hung, the watchdog, and the shadow file to 0; state goes to RUN.
REQ-032 wb_valid during reset or in the cycle of deassertion SHALL be ignored; the first commit is accepted at the first edge with resetn high.
REQ-033 Reset during an io_commit_valid pulse SHALL drop the pulse at once; no partial GPR update survives.

Verification
REQ-034 Commit pc=0xBFC00000, instr=0x24080005, wen=1, waddr=8, wdata=5 -> next cycle: valid=1, pc=0xBFC00000, io_commit_gpr_8=5, commit_count=1; valid=0 the cycle after.
REQ-035 Commit with wen=1, waddr=0, wdata=0xDEADBEEF -> io_commit_gpr_0=0, commit_count increments, pulse present.
REQ-036 Three back-to-back commits writing r2 = 1, 2, 3 -> three consecutive pulses showing io_commit_gpr_2 = 1, 2, 3.
REQ-037 Commit instr=0x1000FFFF, then a delay slot writing r9=7, then 5 more wb_valid -> two pulses only, r9=7, halted=1, commit_count frozen at 2.
REQ-038 TIMEOUT=16, no wb_valid for 16 cycles after the last commit -> hung=1; a later wb_valid produces no pulse; wb_valid exactly on the 16th cycle -> accepted and hung stays 0.
REQ-039 Assert resetn low mid-pulse with r5=0x1234 -> all outputs 0 without a clock edge; after release, the first commit shows commit_count=1.
